// File: rtl/mem_bus_arb.sv
// Two-master round-robin arbiter and sequencer for the shared RAM/MMIO/ROM bus.
// It grants one request at a time, holds the region select for the region's wait states and returns a ready pulse.
module mem_bus_arb #(
   parameter int RAM_WAIT  = 1,
   parameter int MMIO_WAIT = 1,
   parameter int ROM_WAIT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   input  logic        m1_enable,
   output logic [31:0] bus_adr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wren,
   output logic        ram_sel,
   output logic        mmio_sel,
   output logic        rom_sel,
   input  logic [31:0] bus_rdata,
   output logic        grant,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  wstrb_q;
   logic [3:0]  busWren_q;
   logic [1:0]  region_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] m0Rdata_q;
   logic [31:0] m1Rdata_q;
   logic        grant_q;
   logic        lastGrant_q;
   logic        ramSel_q;
   logic        mmioSel_q;
   logic        romSel_q;
   logic        m0Ready_q;
   logic        m1Ready_q;
   logic        busErr_q;

   logic        req0;
   logic        req1;
   logic        pick1;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic [3:0]  reqWstrb;
   logic [1:0]  reqRegion;
   logic [3:0]  cnt_d;
   logic [31:0] capture;

   function automatic logic [3:0] waitFor(input logic [1:0] region);
      case (region)
         2'b00:   waitFor = 4'(RAM_WAIT);
         2'b01:   waitFor = 4'(MMIO_WAIT);
         2'b10:   waitFor = 4'(ROM_WAIT);
         default: waitFor = 4'd0;
      endcase
   endfunction

   // On a tie the master that was not served last wins.
   assign req0      = m0_valid;
   assign req1      = m1_valid & m1_enable;
   assign pick1     = req1 & (~req0 | ~lastGrant_q);
   assign reqAddr   = pick1 ? m1_addr  : m0_addr;
   assign reqWdata  = pick1 ? m1_wdata : m0_wdata;
   assign reqWstrb  = pick1 ? m1_wstrb : m0_wstrb;
   assign reqRegion = reqAddr[17:16];
   assign cnt_d     = cnt_q + 4'd1;
   assign capture   = (region_q == 2'b11) ? 32'd0 : bus_rdata;

   // Outputs are registered one step ahead so wren lands exactly on the cnt==W cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         wstrb_q     <= 4'd0;
         busWren_q   <= 4'd0;
         region_q    <= 2'b00;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         m0Rdata_q   <= 32'd0;
         m1Rdata_q   <= 32'd0;
         grant_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         ramSel_q    <= 1'b0;
         mmioSel_q   <= 1'b0;
         romSel_q    <= 1'b0;
         m0Ready_q   <= 1'b0;
         m1Ready_q   <= 1'b0;
         busErr_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 | req1) begin
                  grant_q   <= pick1;
                  addr_q    <= reqAddr;
                  wdata_q   <= reqWdata;
                  wstrb_q   <= reqWstrb;
                  region_q  <= reqRegion;
                  cnt_q     <= 4'd0;
                  ramSel_q  <= (reqRegion == 2'b00);
                  mmioSel_q <= (reqRegion == 2'b01);
                  romSel_q  <= (reqRegion == 2'b10);
                  busWren_q <= (waitFor(reqRegion) == 4'd0) ? reqWstrb : 4'd0;
                  state_q   <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q == waitFor(region_q)) begin
                  ramSel_q  <= 1'b0;
                  mmioSel_q <= 1'b0;
                  romSel_q  <= 1'b0;
                  busWren_q <= 4'd0;
                  m0Ready_q <= ~grant_q;
                  m1Ready_q <= grant_q;
                  m0Rdata_q <= grant_q ? 32'd0 : capture;
                  m1Rdata_q <= grant_q ? capture : 32'd0;
                  busErr_q  <= (region_q == 2'b11);
                  state_q   <= RESP;
               end else begin
                  cnt_q     <= cnt_d;
                  busWren_q <= (cnt_d == waitFor(region_q)) ? wstrb_q : 4'd0;
               end
            end
            RESP: begin
               m0Ready_q   <= 1'b0;
               m1Ready_q   <= 1'b0;
               m0Rdata_q   <= 32'd0;
               m1Rdata_q   <= 32'd0;
               busErr_q    <= 1'b0;
               lastGrant_q <= grant_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_adr   = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_wren  = busWren_q;
   assign ram_sel   = ramSel_q;
   assign mmio_sel  = mmioSel_q;
   assign rom_sel   = romSel_q;
   assign m0_ready  = m0Ready_q;
   assign m1_ready  = m1Ready_q;
   assign m0_rdata  = m0Rdata_q;
   assign m1_rdata  = m1Rdata_q;
   assign grant     = grant_q;
   assign bus_err   = busErr_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: a transaction-level arbiter model feeds a scoreboard queue,
// and a monitor pops it on every ready pulse while tallying the bus activity of that transaction.
module tb_mem_bus_arb;

   localparam int RAM_W  = 3;
   localparam int MMIO_W = 2;
   localparam int ROM_W  = 1;

   typedef struct {
      logic        who;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  wstrb;
      logic [1:0]  region;
      int          readyCyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0Valid, m1Valid, m1Enable;
   logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;
   logic [3:0]  m0Wstrb, m1Wstrb;
   logic        m0Ready, m1Ready;
   logic [31:0] m0Rdata, m1Rdata;
   logic [31:0] busAdr, busWdata, busRdata;
   logic [3:0]  busWren;
   logic        ramSel, mmioSel, romSel, grant, busErr;

   int   compared = 0;
   int   mismatched = 0;
   int   edgeN = 0;
   int   freeAt = 0;
   logic lastServed = 1'b1;
   int   selRun = 0;
   exp_t expQ[$];

   mem_bus_arb #(.RAM_WAIT(RAM_W), .MMIO_WAIT(MMIO_W), .ROM_WAIT(ROM_W)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0Valid), .m0_addr(m0Addr), .m0_wdata(m0Wdata), .m0_wstrb(m0Wstrb),
      .m0_ready(m0Ready), .m0_rdata(m0Rdata),
      .m1_valid(m1Valid), .m1_addr(m1Addr), .m1_wdata(m1Wdata), .m1_wstrb(m1Wstrb),
      .m1_ready(m1Ready), .m1_rdata(m1Rdata), .m1_enable(m1Enable),
      .bus_adr(busAdr), .bus_wdata(busWdata), .bus_wren(busWren),
      .ram_sel(ramSel), .mmio_sel(mmioSel), .rom_sel(romSel),
      .bus_rdata(busRdata), .grant(grant), .bus_err(busErr)
   );

   always #5 clk = ~clk;

   function automatic int waitOf(input logic [1:0] r);
      case (r)
         2'b00:   return RAM_W;
         2'b01:   return MMIO_W;
         2'b10:   return ROM_W;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] slaveWord(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'hC0DE_0000;
   endfunction

   // The slave only presents real data on the last select cycle, so an early or late capture is visible.
   always @(posedge clk) selRun <= (ramSel | mmioSel | romSel) ? selRun + 1 : 0;
   assign busRdata = ((ramSel | mmioSel | romSel) && selRun == waitOf(busAdr[17:16]))
                     ? slaveWord(busAdr) : (32'hBAD0_0000 | 32'(selRun));

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference model: a free bus takes the round-robin pick of eligible masters and stays busy W+3 cycles.
   always @(posedge clk) begin
      exp_t e;
      logic e0, e1;
      edgeN = edgeN + 1;
      if (reset) begin
         expQ.delete();
         freeAt = edgeN + 1;
         lastServed = 1'b1;
      end else if (edgeN >= freeAt) begin
         e0 = m0Valid;
         e1 = m1Valid & m1Enable;
         if (e0 || e1) begin
            e.who      = (e0 && e1) ? ~lastServed : e1;
            e.addr     = e.who ? m1Addr  : m0Addr;
            e.wdata    = e.who ? m1Wdata : m0Wdata;
            e.wstrb    = e.who ? m1Wstrb : m0Wstrb;
            e.region   = e.addr[17:16];
            e.rdata    = (e.region == 2'b11) ? 32'd0 : slaveWord(e.addr);
            e.readyCyc = edgeN + waitOf(e.region) + 1;
            freeAt     = edgeN + waitOf(e.region) + 3;
            lastServed = e.who;
            expQ.push_back(e);
         end
      end
   end

   // Monitor: tallies selects/wren per transaction and scores each ready pulse against the queue head.
   int          selCnt [3];
   int          lastSelEdge, wrenCnt, wrenEdge;
   logic [3:0]  wrenVal;
   always @(negedge clk) begin
      exp_t m;
      int   ri, others;
      if (m0Ready || m1Ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_ready", {30'd0, m1Ready, m0Ready}, 32'd0);
         end else begin
            m  = expQ.pop_front();
            ri = int'(m.region);
            checkOutput("ready_pair", {30'd0, m1Ready, m0Ready}, m.who ? 32'd2 : 32'd1);
            checkOutput("ready_cycle", edgeN, m.readyCyc);
            checkOutput("rdata", m.who ? m1Rdata : m0Rdata, m.rdata);
            checkOutput("other_rdata", m.who ? m0Rdata : m1Rdata, 32'd0);
            checkOutput("bus_err", {31'd0, busErr}, (m.region == 2'b11) ? 32'd1 : 32'd0);
            checkOutput("grant", {31'd0, grant}, {31'd0, m.who});
            checkOutput("bus_adr", busAdr, m.addr);
            checkOutput("bus_wdata", busWdata, m.wdata);
            others = selCnt[0] + selCnt[1] + selCnt[2];
            if (ri != 3) begin
               checkOutput("sel_cycles", selCnt[ri], waitOf(m.region) + 1);
               checkOutput("stray_sel", others - selCnt[ri], 0);
               checkOutput("last_sel_cycle", lastSelEdge, m.readyCyc - 1);
            end else begin
               checkOutput("stray_sel", others, 0);
            end
            checkOutput("wren_cycles", wrenCnt, (m.wstrb != 4'd0) ? 32'd1 : 32'd0);
            if (m.wstrb != 4'd0) begin
               checkOutput("wren_value", {28'd0, wrenVal}, {28'd0, m.wstrb});
               checkOutput("wren_cycle", wrenEdge, m.readyCyc - 1);
            end
         end
         for (int i = 0; i < 3; i++) selCnt[i] = 0;
         wrenCnt = 0;
      end else if (busErr) begin
         checkOutput("spurious_bus_err", 32'd1, 32'd0);
      end
      if (reset) begin
         for (int i = 0; i < 3; i++) selCnt[i] = 0;
         wrenCnt = 0;
      end else begin
         if (ramSel)  begin selCnt[0]++; lastSelEdge = edgeN; end
         if (mmioSel) begin selCnt[1]++; lastSelEdge = edgeN; end
         if (romSel)  begin selCnt[2]++; lastSelEdge = edgeN; end
         if (busWren != 4'd0) begin wrenCnt++; wrenVal = busWren; wrenEdge = edgeN; end
      end
   end

   // Issue one request from the given master and hold valid until its ready pulse.
   task automatic applyStimulus(input logic who, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws);
      int n = 0;
      if (who) begin m1Valid = 1'b1; m1Addr = a; m1Wdata = wd; m1Wstrb = ws; end
      else     begin m0Valid = 1'b1; m0Addr = a; m0Wdata = wd; m0Wstrb = ws; end
      do begin
         @(negedge clk);
         n++;
      end while (!(who ? m1Ready : m0Ready) && n < 40);
      if (n >= 40) checkOutput("request_timeout", 32'd0, 32'd1);
      m0Valid = 1'b0;
      m1Valid = 1'b0;
   endtask

   initial begin
      int n, pulses;
      logic act0, act1;
      reset = 1'b1;
      m0Valid = 1'b0; m0Addr = '0; m0Wdata = '0; m0Wstrb = '0;
      m1Valid = 1'b0; m1Addr = '0; m1Wdata = '0; m1Wstrb = '0;
      m1Enable = 1'b1;
      for (int i = 0; i < 3; i++) selCnt[i] = 0;
      wrenCnt = 0; wrenVal = '0; lastSelEdge = 0; wrenEdge = 0;
      repeat (3) @(negedge clk);
      checkOutput("rst_sel", {29'd0, ramSel, mmioSel, romSel}, 32'd0);
      checkOutput("rst_wren", {28'd0, busWren}, 32'd0);
      checkOutput("rst_ready", {30'd0, m1Ready, m0Ready}, 32'd0);
      checkOutput("rst_rdata", m0Rdata | m1Rdata, 32'd0);
      checkOutput("rst_adr", busAdr, 32'd0);
      checkOutput("rst_wdata", busWdata, 32'd0);
      checkOutput("rst_grant", {31'd0, grant}, 32'd0);
      checkOutput("rst_err", {31'd0, busErr}, 32'd0);
      reset = 1'b0;

      // Both masters requesting continuously: the scoreboard expects strict alternation from m0.
      m0Valid = 1'b1; m0Addr = 32'h0000_0100; m0Wdata = 32'h1111_0000; m0Wstrb = 4'd0;
      m1Valid = 1'b1; m1Addr = 32'h0001_0200; m1Wdata = 32'h2222_0000; m1Wstrb = 4'd0;
      pulses = 0; n = 0;
      while (pulses < 8 && n < 200) begin
         @(negedge clk);
         n++;
         if (m0Ready || m1Ready) pulses++;
      end
      if (pulses < 8) checkOutput("alternate_timeout", 32'(pulses), 32'd8);
      m0Valid = 1'b0; m1Valid = 1'b0;
      @(negedge clk);

      applyStimulus(1'b1, 32'h0002_0004, 32'h0, 4'b0000);
      applyStimulus(1'b0, 32'h0000_0010, 32'h1234_5678, 4'b1111);
      applyStimulus(1'b1, 32'h0003_0000, 32'h0, 4'b0000);
      applyStimulus(1'b0, 32'h0003_0040, 32'hCAFE_F00D, 4'b0011);

      // m1 gated by m1_enable: nothing may start until the gate opens.
      m1Enable = 1'b0; m1Valid = 1'b1; m1Addr = 32'h0001_0008; m1Wdata = 32'hA5A5_A5A5; m1Wstrb = 4'b0101;
      repeat (6) begin
         @(negedge clk);
         checkOutput("gated_sel", {29'd0, ramSel, mmioSel, romSel}, 32'd0);
      end
      m1Enable = 1'b1;
      @(negedge clk);
      checkOutput("enable_start", {31'd0, mmioSel}, 32'd1);
      m1Valid = 1'b0;
      n = 0;
      while (!m1Ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);

      // Reset in the middle of an access drops it; a fresh request then completes normally.
      m1Valid = 1'b1; m1Addr = 32'h0000_0020; m1Wdata = 32'h0BAD_CAFE; m1Wstrb = 4'b1111;
      n = 0;
      while (!ramSel && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      m1Valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_sel", {29'd0, ramSel, mmioSel, romSel}, 32'd0);
      checkOutput("midrst_wren", {28'd0, busWren}, 32'd0);
      checkOutput("midrst_ready", {30'd0, m1Ready, m0Ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 32'h0002_0100, 32'h0, 4'b0000);

      // Random traffic: valids may drop mid-transaction and the gate toggles freely.
      act0 = 1'b0; act1 = 1'b0;
      repeat (2500) begin
         @(negedge clk);
         m1Enable = ($urandom_range(0, 9) != 0);
         if (act0 && (m0Ready || $urandom_range(0, 19) == 0)) begin
            act0 = 1'b0; m0Valid = 1'b0;
         end else if (!act0 && $urandom_range(0, 2) == 0) begin
            act0 = 1'b1; m0Valid = 1'b1;
            m0Addr = $urandom; m0Wdata = $urandom;
            m0Wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
         end
         if (act1 && (m1Ready || $urandom_range(0, 19) == 0)) begin
            act1 = 1'b0; m1Valid = 1'b0;
         end else if (!act1 && $urandom_range(0, 2) == 0) begin
            act1 = 1'b1; m1Valid = 1'b1;
            m1Addr = $urandom; m1Wdata = $urandom;
            m1Wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
         end
      end
      m0Valid = 1'b0; m1Valid = 1'b0;

      n = 0;
      while (expQ.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (expQ.size() != 0) checkOutput("drain", 32'(expQ.size()), 32'd0);
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
